// File: rtl/adc16dv160_idelay_calib_if.sv
// Signal bundle between the IDELAY calibration controller and its surroundings.
// The master side drives start, readiness, capture data and pattern. The slave side returns tap loads and status.
interface adc16dv160_idelay_calib_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned TAPS  = 32
);
  localparam int unsigned TapW = $clog2(TAPS);
  localparam int unsigned LenW = $clog2(TAPS + 1);

  logic                   start;
  logic                   idelay_rdy;
  logic [2*LANES-1:0]     adc_data;
  logic [2*LANES-1:0]     pattern;
  logic [TapW*LANES-1:0]  idelay_cnt;
  logic [LANES-1:0]       idelay_ld;
  logic                   busy;
  logic                   done;
  logic [LANES-1:0]       lane_ok;
  logic [LenW*LANES-1:0]  lane_win;

  modport master (
    output start, idelay_rdy, adc_data, pattern,
    input  idelay_cnt, idelay_ld, busy, done, lane_ok, lane_win
  );

  modport slave (
    input  start, idelay_rdy, adc_data, pattern,
    output idelay_cnt, idelay_ld, busy, done, lane_ok, lane_win
  );
endinterface

// File: rtl/adc16dv160_idelay_calib.sv
// Per-lane IDELAYE2 tap sweep against a static ADC test pattern.
// Each lane is loaded with the centre of its widest, earliest passing window.
module adc16dv160_idelay_calib #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned TAPS    = 32,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned SAMPLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  adc16dv160_idelay_calib_if.slave      if_calib
);

  localparam int unsigned TapW   = $clog2(TAPS);
  localparam int unsigned LenW   = $clog2(TAPS + 1);
  localparam int unsigned LaneW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CntMax = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StLoad, StSettle, StCheck, StUpdate, StApply, StDone
  } state_e;

  state_e                r_state, w_state_nxt;
  logic                  r_rdy_meta, r_rdy_sync;
  logic [LaneW-1:0]      r_lane, w_lane_nxt;
  logic [TapW-1:0]       r_tap, w_tap_nxt;
  logic [CntW-1:0]       r_cyc, w_cyc_nxt;
  logic                  r_fail, w_fail_nxt;
  logic [LenW-1:0]       r_cur_len, w_cur_len_nxt;
  logic [LenW-1:0]       r_best_len, w_best_len_nxt;
  logic [TapW-1:0]       r_cur_start, w_cur_start_nxt;
  logic [TapW-1:0]       r_best_start, w_best_start_nxt;
  logic [TapW*LANES-1:0] r_cnt, w_cnt_out;
  logic [LANES-1:0]      w_ld;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [LANES-1:0]      r_lane_ok, w_lane_ok_nxt;
  logic [LenW*LANES-1:0] r_lane_win, w_lane_win_nxt;

  logic                  w_match;
  logic [TapW-1:0]       w_pass_start;
  logic [LenW-1:0]       w_pass_len;
  logic [TapW-1:0]       w_half;
  logic [TapW-1:0]       w_centre;

  // Raw lane bits are compared directly; no capture register in front.
  assign w_match      = (if_calib.adc_data[2*r_lane +: 2] == if_calib.pattern[2*r_lane +: 2]);
  assign w_pass_start = (r_cur_len == '0) ? r_tap : r_cur_start;
  assign w_pass_len   = r_cur_len + 1'b1;
  assign w_half       = TapW'((r_best_len - 1'b1) >> 1);
  assign w_centre     = r_best_start + w_half;

  always_comb begin
    w_state_nxt      = r_state;
    w_lane_nxt       = r_lane;
    w_tap_nxt        = r_tap;
    w_cyc_nxt        = r_cyc;
    w_fail_nxt       = r_fail;
    w_cur_len_nxt    = r_cur_len;
    w_best_len_nxt   = r_best_len;
    w_cur_start_nxt  = r_cur_start;
    w_best_start_nxt = r_best_start;
    w_cnt_out        = r_cnt;
    w_ld             = '0;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_lane_ok_nxt    = r_lane_ok;
    w_lane_win_nxt   = r_lane_win;

    case (r_state)
      StIdle: begin
        if (if_calib.start) begin
          w_state_nxt      = StWaitRdy;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_lane_ok_nxt    = '0;
          w_lane_win_nxt   = '0;
          w_lane_nxt       = '0;
          w_tap_nxt        = '0;
          w_cyc_nxt        = '0;
          w_fail_nxt       = 1'b0;
          w_cur_len_nxt    = '0;
          w_best_len_nxt   = '0;
          w_cur_start_nxt  = '0;
          w_best_start_nxt = '0;
        end
      end
      StWaitRdy: begin
        if (r_rdy_sync) w_state_nxt = StLoad;
      end
      StLoad: begin
        w_ld[r_lane]                    = 1'b1;
        w_cnt_out[TapW*r_lane +: TapW] = r_tap;
        w_cyc_nxt                       = '0;
        w_state_nxt                     = StSettle;
      end
      StSettle: begin
        if (r_cyc == CntW'(SETTLE - 1)) begin
          w_cyc_nxt   = '0;
          w_state_nxt = StCheck;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      StCheck: begin
        if (!w_match) w_fail_nxt = 1'b1;
        if (r_cyc == CntW'(SAMPLES - 1)) begin
          w_cyc_nxt   = '0;
          w_state_nxt = StUpdate;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      StUpdate: begin
        if (!r_fail) begin
          w_cur_start_nxt = w_pass_start;
          w_cur_len_nxt   = w_pass_len;
          // Strictly greater keeps the earliest of equal-length windows.
          if (w_pass_len > r_best_len) begin
            w_best_start_nxt = w_pass_start;
            w_best_len_nxt   = w_pass_len;
          end
        end else begin
          w_cur_len_nxt = '0;
        end
        w_fail_nxt = 1'b0;
        if (r_tap == TapW'(TAPS - 1)) begin
          w_state_nxt = StApply;
        end else begin
          w_tap_nxt   = r_tap + 1'b1;
          w_state_nxt = StLoad;
        end
      end
      StApply: begin
        w_ld[r_lane]                         = 1'b1;
        w_cnt_out[TapW*r_lane +: TapW]      = (r_best_len != '0) ? w_centre : '0;
        w_lane_ok_nxt[r_lane]                = (r_best_len != '0);
        w_lane_win_nxt[LenW*r_lane +: LenW] = r_best_len;
        w_cur_len_nxt                        = '0;
        w_best_len_nxt                       = '0;
        w_best_start_nxt                     = '0;
        w_tap_nxt                            = '0;
        if (r_lane == LaneW'(LANES - 1)) begin
          w_state_nxt = StDone;
        end else begin
          w_lane_nxt  = r_lane + 1'b1;
          w_state_nxt = StLoad;
        end
      end
      StDone: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_rdy_meta   <= 1'b0;
      r_rdy_sync   <= 1'b0;
      r_lane       <= '0;
      r_tap        <= '0;
      r_cyc        <= '0;
      r_fail       <= 1'b0;
      r_cur_len    <= '0;
      r_best_len   <= '0;
      r_cur_start  <= '0;
      r_best_start <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lane_ok    <= '0;
      r_lane_win   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rdy_meta   <= if_calib.idelay_rdy;
      r_rdy_sync   <= r_rdy_meta;
      r_lane       <= w_lane_nxt;
      r_tap        <= w_tap_nxt;
      r_cyc        <= w_cyc_nxt;
      r_fail       <= w_fail_nxt;
      r_cur_len    <= w_cur_len_nxt;
      r_best_len   <= w_best_len_nxt;
      r_cur_start  <= w_cur_start_nxt;
      r_best_start <= w_best_start_nxt;
      r_cnt        <= w_cnt_out;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_lane_ok    <= w_lane_ok_nxt;
      r_lane_win   <= w_lane_win_nxt;
    end
  end

  assign if_calib.idelay_cnt = w_cnt_out;
  assign if_calib.idelay_ld  = w_ld;
  assign if_calib.busy       = r_busy;
  assign if_calib.done       = r_done;
  assign if_calib.lane_ok    = r_lane_ok;
  assign if_calib.lane_win   = r_lane_win;

endmodule
